// File: rtl/hp_control.sv
`default_nettype none
// ============================================================================
// Module      : hp_control
// Description : Player hit-point controller. Tracks HP, produces a timed
//               hit-flash after each survivable hit, flags player death and
//               drives an HP bar width (hp * BAR_STEP pixels).
// Ports       : pclk             - system clock, rising edge
//               rst              - synchronous active-high reset
//               damage_in        - one-cycle hit pulse
//               restart_in       - level-sampled new-game request
//               hp_out           - current hit points (0..15)
//               hp_bar_width_out - HP bar width in pixels (12 bit, truncated)
//               hit_flash_out    - high while the hit flash is active
//               player_dead_out  - high while the player is dead
// Revision    : 1.0 - initial release
// ============================================================================
module hp_control #(
  parameter int MAX_HP       = 5,
  parameter int FLASH_CYCLES = 6500000,
  parameter int BAR_STEP     = 40
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        damage_in,
  input  logic        restart_in,
  output logic [3:0]  hp_out,
  output logic [11:0] hp_bar_width_out,
  output logic        hit_flash_out,
  output logic        player_dead_out
);

  // FSM encoding
  localparam logic [1:0] c_st_alive = 2'd0;
  localparam logic [1:0] c_st_flash = 2'd1;
  localparam logic [1:0] c_st_dead  = 2'd2;

  localparam logic [3:0]  c_max_hp    = 4'(MAX_HP);
  localparam logic [11:0] c_bar_step  = 12'(BAR_STEP);
  localparam logic [11:0] c_bar_reset = 12'(MAX_HP * BAR_STEP);
  // Terminal count of the flash counter; a zero duration degenerates to one
  // cycle rather than letting the counter run away.
  localparam logic [27:0] c_flash_last =
    (FLASH_CYCLES > 0) ? 28'(FLASH_CYCLES - 1) : 28'd0;

  logic [1:0]  r_state;
  logic [3:0]  r_hp;
  logic [27:0] r_cnt;
  logic [11:0] r_bar;
  logic        r_flash;
  logic        r_dead;

  logic [1:0]  w_state_next;
  logic [3:0]  w_hp_next;
  logic [27:0] w_cnt_next;
  logic [11:0] w_bar_next;

  // Shared hit handling for ALIVE and FLASH: a hit with more than one HP left
  // (re)starts the flash, the last HP kills the player.
  always_comb begin
    w_state_next = r_state;
    w_hp_next    = r_hp;
    w_cnt_next   = r_cnt;

    if (restart_in) begin
      w_state_next = c_st_alive;
      w_hp_next    = c_max_hp;
      w_cnt_next   = 28'd0;
    end else begin
      case (r_state)
        c_st_alive: begin
          if (damage_in) begin
            w_cnt_next = 28'd0;
            if (r_hp > 4'd1) begin
              w_hp_next    = r_hp - 4'd1;
              w_state_next = c_st_flash;
            end else begin
              w_hp_next    = 4'd0;
              w_state_next = c_st_dead;
            end
          end
        end

        c_st_flash: begin
          if (damage_in) begin
            w_cnt_next = 28'd0;
            if (r_hp > 4'd1) begin
              w_hp_next    = r_hp - 4'd1;
              w_state_next = c_st_flash;
            end else begin
              w_hp_next    = 4'd0;
              w_state_next = c_st_dead;
            end
          end else if (r_cnt == c_flash_last) begin
            w_cnt_next   = 28'd0;
            w_state_next = c_st_alive;
          end else begin
            w_cnt_next = r_cnt + 28'd1;
          end
        end

        c_st_dead: begin
          // Damage is ignored; HP stays pinned at zero.
          w_hp_next  = 4'd0;
          w_cnt_next = 28'd0;
        end

        default: begin
          w_state_next = c_st_alive;
          w_hp_next    = c_max_hp;
          w_cnt_next   = 28'd0;
        end
      endcase
    end
  end

  // Bar follows the next-state HP so it changes on the same edge as hp_out.
  // The 12-bit product context gives the required truncation.
  assign w_bar_next = {8'd0, w_hp_next} * c_bar_step;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= c_st_alive;
      r_hp    <= c_max_hp;
      r_cnt   <= 28'd0;
      r_bar   <= c_bar_reset;
      r_flash <= 1'b0;
      r_dead  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hp    <= w_hp_next;
      r_cnt   <= w_cnt_next;
      r_bar   <= w_bar_next;
      r_flash <= (w_state_next == c_st_flash);
      r_dead  <= (w_state_next == c_st_dead);
    end
  end

  assign hp_out           = r_hp;
  assign hp_bar_width_out = r_bar;
  assign hit_flash_out    = r_flash;
  assign player_dead_out  = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_hp_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_hp_control
// Description : Scoreboard bench for hp_control. A driver applies directed
//               and random stimulus and pushes the reference model's expected
//               outputs into a queue; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hp_control;

  localparam int c_max_hp   = 5;
  localparam int c_flash    = 4;
  localparam int c_bar_step = 40;

  logic        pclk;
  logic        rst;
  logic        damage_in;
  logic        restart_in;
  logic [3:0]  hp_out;
  logic [11:0] hp_bar_width_out;
  logic        hit_flash_out;
  logic        player_dead_out;

  hp_control #(
    .MAX_HP       (c_max_hp),
    .FLASH_CYCLES (c_flash),
    .BAR_STEP     (c_bar_step)
  ) u_dut (
    .pclk             (pclk),
    .rst              (rst),
    .damage_in        (damage_in),
    .restart_in       (restart_in),
    .hp_out           (hp_out),
    .hp_bar_width_out (hp_bar_width_out),
    .hit_flash_out    (hit_flash_out),
    .player_dead_out  (player_dead_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int hp;
    int bar;
    bit flash;
    bit dead;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  // Reference model: HP count, remaining flash cycles and a dead flag.
  int m_hp = c_max_hp;
  int m_flash_left = 0;
  bit m_dead = 1'b0;

  task automatic model_step(input bit r, input bit rs, input bit d);
    exp_t e;
    if (r || rs) begin
      m_hp = c_max_hp;
      m_flash_left = 0;
      m_dead = 1'b0;
    end else if (d && !m_dead) begin
      if (m_hp > 1) begin
        m_hp = m_hp - 1;
        m_flash_left = c_flash;
      end else begin
        m_hp = 0;
        m_dead = 1'b1;
        m_flash_left = 0;
      end
    end else if (m_flash_left > 0) begin
      m_flash_left = m_flash_left - 1;
    end
    e.hp    = m_hp;
    e.bar   = (m_hp * c_bar_step) % 4096;
    e.flash = (m_flash_left > 0);
    e.dead  = m_dead;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit rs, input bit d, input int n = 1);
    repeat (n) begin
      @(negedge pclk);
      rst = r;
      restart_in = rs;
      damage_in = d;
      @(posedge pclk);
      model_step(r, rs, d);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hp_out", int'(hp_out), e.hp);
        check("hp_bar_width_out", int'(hp_bar_width_out), e.bar);
        check("hit_flash_out", int'(hit_flash_out), int'(e.flash));
        check("player_dead_out", int'(player_dead_out), int'(e.dead));
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1;
    restart_in = 1'b0;
    damage_in = 1'b0;

    // Reset for two cycles, then idle.
    cyc(1, 0, 0, 2);
    cyc(0, 0, 0, 3);

    // Single hit: flash for exactly four cycles.
    cyc(0, 0, 1);
    cyc(0, 0, 0, 8);

    // Hit during flash, two cycles into it, from full HP.
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 8);

    // Death: five hits ten cycles apart, then an ignored hit.
    cyc(0, 1, 0);
    repeat (5) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0, 9);
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0, 3);

    // Restart has priority over a simultaneous hit while dead.
    cyc(0, 1, 1);
    cyc(0, 0, 0, 2);

    // Reset one cycle after a hit aborts the flash.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0, 5);

    // Back-to-back hits, then reset overriding restart and damage.
    cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 2);
    cyc(1, 1, 1);
    cyc(0, 0, 0, 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) == 0));
    end
    cyc(0, 0, 0, 3);
    drv_done = 1'b1;
  end

  // Wrap-up: bounded drain of the scoreboard, then summary.
  initial begin
    int budget;
    wait (drv_done);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge pclk);
      budget--;
    end
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
